// File: rtl/digit_rotator.sv
// Multi-digit display register: rotates, holds or shifts in digits on a prescaled tick; optional blank_mask via DIGIT_ROTATOR_BLANK_EN.
// Latency: loads and steps are visible on digits/tick_out one cycle after the accepting or firing edge.
// Backpressure: load_ready drops for one cycle after each accepted load; a load on a firing edge drops that step.
module digit_rotator #(
    parameter int DIGIT_W    = 4,
    parameter int NUM_DIGITS = 8,
    parameter int DIV_W      = 24
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [1:0]                    mode,
    input  logic [DIV_W-1:0]              step_div,
    input  logic [DIGIT_W-1:0]            shift_in,
    input  logic                          load_valid,
    input  logic [DIGIT_W*NUM_DIGITS-1:0] load_data,
    output logic                          load_ready,
    output logic [DIGIT_W*NUM_DIGITS-1:0] digits,
    output logic                          tick_out
`ifdef DIGIT_ROTATOR_BLANK_EN
    ,
    output logic [NUM_DIGITS-1:0]         blank_mask
`endif
);

    localparam int VW = DIGIT_W * NUM_DIGITS;

    localparam logic [1:0] MODE_ROL   = 2'b00;
    localparam logic [1:0] MODE_ROR   = 2'b01;
    localparam logic [1:0] MODE_SHIFT = 2'b11;

    // Digit i powers up showing i+1, wrapped to the digit width.
    function automatic logic [VW-1:0] reset_digits();
        logic [VW-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            v[DIGIT_W*i +: DIGIT_W] = DIGIT_W'(i + 1);
        end
        return v;
    endfunction

    localparam logic [VW-1:0] RESET_DIGITS = reset_digits();

    logic [DIV_W-1:0] count;
    logic [VW-1:0]    next_digits;
    logic             fire;
    logic             accept;

    assign fire   = (count >= step_div);
    assign accept = load_valid && load_ready;

    always_comb begin
        next_digits = digits;
        case (mode)
            MODE_ROL:   next_digits = {digits[VW-DIGIT_W-1:0], digits[VW-1 -: DIGIT_W]};
            MODE_ROR:   next_digits = {digits[DIGIT_W-1:0], digits[VW-1:DIGIT_W]};
            MODE_SHIFT: next_digits = {digits[VW-DIGIT_W-1:0], shift_in};
            default:    next_digits = digits;
        endcase
    end

    // A load on a firing edge restarts the prescaler and swallows the step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digits     <= RESET_DIGITS;
            count      <= '0;
            load_ready <= 1'b1;
            tick_out   <= 1'b0;
        end else begin
            load_ready <= !accept;
            tick_out   <= fire && !accept;
            if (accept) begin
                digits <= load_data;
                count  <= '0;
            end else if (fire) begin
                digits <= next_digits;
                count  <= '0;
            end else begin
                count  <= count + DIV_W'(1);
            end
        end
    end

`ifdef DIGIT_ROTATOR_BLANK_EN
    // Leading-zero digits above index 0 are blanked; digit 0 always shows.
    function automatic logic [NUM_DIGITS-1:0] blank_of(input logic [VW-1:0] v);
        logic [NUM_DIGITS-1:0] m;
        logic                  zero_above;
        m          = '0;
        zero_above = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            if (v[DIGIT_W*i +: DIGIT_W] != '0) zero_above = 1'b0;
            m[i] = zero_above;
        end
        return m;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blank_mask <= '0;
        end else if (accept) begin
            blank_mask <= blank_of(load_data);
        end else if (fire) begin
            blank_mask <= blank_of(next_digits);
        end
    end
`endif

endmodule

// File: tb/tb_digit_rotator.sv
// Bench for digit_rotator: a cycle model pushes expected outputs per edge into a scoreboard queue.
// Directed cases follow the documented scenarios, then a randomized mix of modes, dividers and loads.
module tb_digit_rotator;

    localparam int W  = 4;
    localparam int N  = 8;
    localparam int DW = 24;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [1:0]      mode = 2'b00;
    logic [DW-1:0]   step_div = '0;
    logic [W-1:0]    shift_in = '0;
    logic            load_valid = 1'b0;
    logic [W*N-1:0]  load_data = '0;
    logic            load_ready;
    logic [W*N-1:0]  digits;
    logic            tick_out;
`ifdef DIGIT_ROTATOR_BLANK_EN
    logic [N-1:0]    blank_mask;
`endif

    digit_rotator #(.DIGIT_W(W), .NUM_DIGITS(N), .DIV_W(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .mode       (mode),
        .step_div   (step_div),
        .shift_in   (shift_in),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (load_ready),
        .digits     (digits),
        .tick_out   (tick_out)
`ifdef DIGIT_ROTATOR_BLANK_EN
        ,
        .blank_mask (blank_mask)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W*N-1:0] dig;
        logic           tick;
        logic           rdy;
        logic [N-1:0]   blank;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    logic [W-1:0] md[N];
    int           mcount;
    logic         mready;
    logic         mtick;
    logic [N-1:0] mblank;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [W*N-1:0] mpack();
        logic [W*N-1:0] v;
        for (int i = 0; i < N; i++) v[W*i +: W] = md[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) md[i] = W'(i + 1);
        mcount = 0;
        mready = 1'b1;
        mtick  = 1'b0;
        mblank = '0;
    endtask

    task automatic model_blank();
        logic all_zero;
        mblank = '0;
        for (int i = 1; i < N; i++) begin
            all_zero = 1'b1;
            for (int j = i; j < N; j++) if (md[j] != 0) all_zero = 1'b0;
            mblank[i] = all_zero;
        end
    endtask

    // Advance the model across one rising edge using the currently driven inputs.
    task automatic model_edge();
        logic [W-1:0] old[N];
        logic         fire;
        logic         acc;
        fire = (mcount >= int'(step_div));
        acc  = load_valid && mready;
        for (int i = 0; i < N; i++) old[i] = md[i];
        if (acc) begin
            for (int i = 0; i < N; i++) md[i] = load_data[W*i +: W];
            mcount = 0;
            mtick  = 1'b0;
            mready = 1'b0;
            model_blank();
        end else begin
            mready = 1'b1;
            mtick  = fire;
            if (fire) begin
                mcount = 0;
                for (int i = 0; i < N; i++) begin
                    case (mode)
                        2'b00: md[i] = (i == 0) ? old[N-1] : old[i-1];
                        2'b01: md[i] = (i == N-1) ? old[0] : old[i+1];
                        2'b11: md[i] = (i == 0) ? shift_in : old[i-1];
                        default: md[i] = old[i];
                    endcase
                end
                model_blank();
            end else begin
                mcount++;
            end
        end
    endtask

    // Inputs are set by the caller at a falling edge; outputs are checked at the next falling edge.
    task automatic cycle();
        exp_t e;
        model_edge();
        e.dig   = mpack();
        e.tick  = mtick;
        e.rdy   = mready;
        e.blank = mblank;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        if (sb.size() == 0) begin
            check_eq("sb_empty", 64'd0, 64'd1);
        end else begin
            e = sb.pop_front();
            check_eq("sb_digits", 64'(digits), 64'(e.dig));
            check_eq("sb_tick", 64'(tick_out), 64'(e.tick));
            check_eq("sb_ready", 64'(load_ready), 64'(e.rdy));
`ifdef DIGIT_ROTATOR_BLANK_EN
            check_eq("sb_blank", 64'(blank_mask), 64'(e.blank));
`endif
        end
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, "_digits"}, 64'(digits), 64'h87654321);
        check_eq({tag, "_ready"}, 64'(load_ready), 64'd1);
        check_eq({tag, "_tick"}, 64'(tick_out), 64'd0);
`ifdef DIGIT_ROTATOR_BLANK_EN
        check_eq({tag, "_blank"}, 64'(blank_mask), 64'd0);
`endif
    endtask

    // Called at a falling edge; reset is checked asynchronously before any clock edge.
    task automatic do_reset(input string tag);
        rst = 1'b1;
        #2;
        check_reset_state(tag);
        model_reset();
        sb.delete();
        @(negedge clk);
        load_valid = 1'b0;
        rst = 1'b0;
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        check_reset_state("por");
        rst = 1'b0;

        // Rotate-left every cycle.
        mode = 2'b00; step_div = '0;
        cycle();
        check_eq("rol_1", 64'(digits), 64'h76543218);
        check_eq("rol_1_tick", 64'(tick_out), 64'd1);
        cycle();
        check_eq("rol_2", 64'(digits), 64'h65432187);
        check_eq("rol_2_tick", 64'(tick_out), 64'd1);

        // Rotate-right every 4 cycles.
        do_reset("rst_ror");
        mode = 2'b01; step_div = 24'd3;
        repeat (3) cycle();
        check_eq("ror_wait", 64'(digits), 64'h87654321);
        cycle();
        check_eq("ror_step", 64'(digits), 64'h18765432);
        check_eq("ror_tick", 64'(tick_out), 64'd1);
        repeat (8) cycle();

        // Shift-in twice.
        do_reset("rst_shift");
        mode = 2'b11; shift_in = 4'hA; step_div = '0;
        repeat (2) cycle();
        check_eq("shift_2", 64'(digits), 64'h654321AA);

        // Load collides with a step; the held request is taken again after the gap.
        do_reset("rst_load");
        mode = 2'b00; step_div = '0;
        load_valid = 1'b1; load_data = 32'h00000042;
        cycle();
        check_eq("load_dig", 64'(digits), 64'h00000042);
        check_eq("load_tick", 64'(tick_out), 64'd0);
        check_eq("load_rdy", 64'(load_ready), 64'd0);
`ifdef DIGIT_ROTATOR_BLANK_EN
        check_eq("load_blank", 64'(blank_mask), 64'hFC);
`endif
        load_data = 32'h12345678;
        cycle();
        check_eq("load_gap_rdy", 64'(load_ready), 64'd1);
        check_eq("load_gap_dig", 64'(digits), 64'h00000420);
        cycle();
        check_eq("load2_dig", 64'(digits), 64'h12345678);
        check_eq("load2_rdy", 64'(load_ready), 64'd0);
        load_valid = 1'b0;
        repeat (3) cycle();

        // Divider lowered below the running count.
        do_reset("rst_div");
        mode = 2'b00; step_div = 24'd100;
        repeat (50) cycle();
        step_div = 24'd2;
        cycle();
        check_eq("div_fire", 64'(tick_out), 64'd1);
        check_eq("div_dig", 64'(digits), 64'h76543218);
        repeat (9) cycle();

        // Hold mode, then asynchronous reset mid-count.
        do_reset("rst_hold");
        mode = 2'b10; step_div = 24'd4;
        repeat (7) cycle();
        check_eq("hold_dig", 64'(digits), 64'h87654321);
        #3;
        do_reset("rst_mid");
        repeat (2) cycle();

        // Randomized mix.
        for (int k = 0; k < 400; k++) begin
            mode       = 2'($urandom_range(0, 3));
            step_div   = DW'($urandom_range(0, 4));
            shift_in   = W'($urandom_range(0, 15));
            load_valid = ($urandom_range(0, 4) == 0);
            load_data  = ($urandom_range(0, 1) == 0) ? (W*N)'($urandom_range(0, 255)) : (W*N)'($urandom);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
